mk14_keypad_scan: RTL and testbench
===================================

Name: mk14_keypad_scan

Overview:
Matrix keypad scanner for the MK14 SoC on the ice40 board; the input-side counterpart of the SoC's multiplexed digit display output. It drives active-low column strobes, samples active-low rows through a synchroniser and debounces each key. It exports a stable key bitmap and a single-entry press/release event stream (valid/ready) that the SoC keyboard port consumes.

Parameters:
CLOCK_FREQ_MHZ, 12, CLK frequency in MHz.
COLS, 8, column strobes (one per MK14 digit position).
ROWS, 4, row sense inputs.
SETTLE_US, 10, column dwell time in µs; SETTLE_CYCLES = CLOCK_FREQ_MHZ*SETTLE_US, must be >= 4 (elaboration error otherwise).
DEBOUNCE_SCANS, 4, consecutive disagreeing samples needed to flip a key's stable state (2..15).

Ports:
CLK  in  1  clock.
rst_n  in  1  synchronous, active-low reset.
col_n  out  COLS  column strobes, one-hot active-low.
row_n  in  ROWS  raw row inputs, active-low (pulled up), asynchronous.
keys  out  COLS*ROWS  stable key bitmap, 1=pressed; bit index = col*ROWS+row.
evt_valid  out  1  event pending.
evt_ready  in  1  consumer accepts event.
evt_code  out  KW=$clog2(COLS*ROWS)  key index of event.
evt_press  out  1  1=press, 0=release.

Behaviour:
- Reset, synchronous on CLK with rst_n=0: col_n all ones; keys=0; evt_valid=0, evt_code=0, evt_press=0; column index 0; all debounce counters 0; synchroniser flops 1. Asserting reset mid-scan or with an event pending discards everything; no event is emitted for keys held across reset.
- row_n passes through a 2-flop synchroniser; the sampled value is inverted to 1=pressed.
- FSM: IDLE -> SETTLE -> SAMPLE -> SETTLE...
  - IDLE: occupies the first cycle after reset release, with col_n all ones. Next state SETTLE with col=0.
  - SETTLE: col_n[col]=0 and all other columns 1. The settle counter counts 0..SETTLE_CYCLES-2, then the state moves to SAMPLE.
  - SAMPLE: one cycle, with col_n still driven. It captures the synchronised rows for that column and updates that column's ROWS debounce counters in parallel. It then advances col, wrapping COLS-1 -> 0, and returns to SETTLE.
  - Column period = SETTLE_CYCLES cycles; scan period = COLS*SETTLE_CYCLES.
- Debounce, per key, applied in SAMPLE:
  - sample == keys[i]: counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_SCANS.
  - Counter reaching DEBOUNCE_SCANS makes the key a commit candidate.
- Commit, at most one per SAMPLE cycle:
  - The lowest-row candidate commits only if the event slot is free (evt_valid=0, or evt_valid&&evt_ready this cycle).
  - Commit toggles keys[i], clears its counter, and loads evt_code=i and evt_press=new keys[i] with evt_valid=1 on the next cycle.
  - Candidates that cannot commit keep their saturated counter and retry on the next scan. No event is ever lost or reordered per key, and keys always equals the accumulated event history.
- Handshake:
  - evt_valid stays high, and code/press stay stable, until evt_valid&&evt_ready.
  - Accept and new commit in the same cycle: the slot reloads, so evt_valid stays 1.
  - Accept without a new commit: evt_valid drops the next cycle.
- A bounce shorter than DEBOUNCE_SCANS samples produces no event and no keys change.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined:
  - Adds parameters REPEAT_DELAY_MS (500) and REPEAT_RATE_MS (100), plus output evt_repeat.
  - The most recently committed pressed key is tracked.
  - If it is still held after REPEAT_DELAY_MS, a press event with evt_repeat=1 is queued, then one every REPEAT_RATE_MS after that.
  - Repeat events use the same slot and lower priority than debounce commits. If the slot is busy, the repeat is deferred, never dropped or doubled.
  - Releasing that key, or pressing another key, cancels repeat.
- Undefined: no evt_repeat port and no repeat logic.

Decomposition:
- Package mk14_keypad_pkg holds:
  - the scan_state_t enum {IDLE, SETTLE, SAMPLE};
  - a function computing KW;
  - the localparam helper for SETTLE_CYCLES.
- One sub-module, mk14_key_debounce: a single key's counter and compare, returning a candidate flag. It is instantiated COLS*ROWS times, with an enable driven in SAMPLE for the active column.

Test Plan:
Bench parameters unless stated: CLOCK_FREQ_MHZ=1, SETTLE_US=4, COLS=8, ROWS=4, DEBOUNCE_SCANS=4 (4 cycles/column, 32 cycles/scan).
- Reset release -> col_n=8'hFF for 1 cycle, then 8'hFE for 4 cycles, then 8'hFD. After 32 cycles col_n returns to 8'hFE; keys=0 and evt_valid=0 throughout.
- Hold row 2 low whenever col 5 is driven, evt_ready=1 -> after the 4th col-5 sample: evt_valid pulses with evt_code=22, evt_press=1, keys[22]=1. Release -> same code with evt_press=0.
- Bounce key 22 pressed for 3 scans, then released -> no event; keys stays 0.
- Keys 4 and 6 (col 1, rows 0 and 2) pressed together, evt_ready=0 -> only code 4 is presented and held stable. Raise evt_ready -> code 6 arrives a scan later; keys[4] and keys[6]=1.
- Assert rst_n=0 with evt_valid=1 and key 22 held -> next cycle evt_valid=0 and keys=0. After release, a press event for 22 is re-emitted after 4 scans.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY_MS=1, REPEAT_RATE_MS=1: hold key 22 -> initial press event with evt_repeat=0, then events with evt_repeat=1 every 1000 cycles (±1 scan) until release.

Source files
------------

// File: rtl/mk14_keypad_pkg.sv
// ============================================================================
// mk14_keypad_pkg : shared types and elaboration helpers for the keypad scanner
// Revision: 1.0
// ============================================================================
`default_nettype none

package mk14_keypad_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2
   } scan_state_t;

   // Debounce counters hold 0..15
   localparam int DB_W = 4;

   function automatic int key_width(input int cols, input int rows);
      return (cols * rows > 1) ? $clog2(cols * rows) : 1;
   endfunction

   function automatic int settle_cycles(input int freq_mhz, input int settle_us);
      return freq_mhz * settle_us;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mk14_key_debounce.sv
// ============================================================================
// mk14_key_debounce : one key's disagreement counter and commit-candidate flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module mk14_key_debounce
   import mk14_keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic CLK,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_sample,
   input  logic i_stable,
   input  logic i_commit,
   output logic o_cand
);

   logic [DB_W-1:0] r_cnt;
   logic            w_differ;

   assign w_differ = i_sample ^ i_stable;
   // Candidate as soon as this sample brings the count to DEBOUNCE_SCANS, or it is already saturated
   assign o_cand   = i_en & w_differ & (r_cnt >= DB_W'(DEBOUNCE_SCANS - 1));

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_commit) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (!w_differ)
            r_cnt <= '0;
         else if (r_cnt != DB_W'(DEBOUNCE_SCANS))
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mk14_keypad_scan.sv
// ============================================================================
// mk14_keypad_scan : MK14 matrix keypad scanner with debounce and event port
// Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mk14_keypad_scan
   import mk14_keypad_pkg::*;
#(
   parameter int CLOCK_FREQ_MHZ  = 12,
   parameter int COLS            = 8,
   parameter int ROWS            = 4,
   parameter int SETTLE_US       = 10,
   parameter int DEBOUNCE_SCANS  = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100,
`endif
   localparam int KW = key_width(COLS, ROWS)
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   output logic [COLS-1:0]      col_n,
   input  logic [ROWS-1:0]      row_n,
   output logic [COLS*ROWS-1:0] keys,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [KW-1:0]        evt_code,
   output logic                 evt_press
`ifdef KEYPAD_AUTOREPEAT_EN
   ,
   output logic                 evt_repeat
`endif
);

   localparam int SETTLE_CYCLES = settle_cycles(CLOCK_FREQ_MHZ, SETTLE_US);
   localparam int NK            = COLS * ROWS;
   localparam int CW            = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW            = $clog2(SETTLE_CYCLES);

   if (SETTLE_CYCLES < 4) begin : g_settle_chk
      $error("mk14_keypad_scan: SETTLE_CYCLES must be >= 4");
   end
   if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_debounce_chk
      $error("mk14_keypad_scan: DEBOUNCE_SCANS must be 2..15");
   end

   logic [ROWS-1:0] r_sync1, r_sync2;
   logic [ROWS-1:0] w_rows;
   scan_state_t     r_state, w_state_nxt;
   logic [CW-1:0]   r_col, w_col_nxt;
   logic [SW-1:0]   r_settle, w_settle_nxt;
   logic            w_sample_en;
   logic [NK-1:0]   r_keys;
   logic [NK-1:0]   w_cand, w_commit_vec;
   logic            w_commit, w_slot_free;
   logic [KW-1:0]   w_commit_idx;
   logic            r_evt_valid, r_evt_press;
   logic [KW-1:0]   r_evt_code;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= row_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rows = ~r_sync2;

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_col    <= '0;
         r_settle <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_col    <= w_col_nxt;
         r_settle <= w_settle_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_col_nxt    = r_col;
      w_settle_nxt = r_settle;
      w_sample_en  = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt  = SETTLE;
            w_col_nxt    = '0;
            w_settle_nxt = '0;
         end
         SETTLE: begin
            if (r_settle == SW'(SETTLE_CYCLES - 2))
               w_state_nxt = SAMPLE;
            else
               w_settle_nxt = r_settle + 1'b1;
         end
         SAMPLE: begin
            w_sample_en  = 1'b1;
            w_state_nxt  = SETTLE;
            w_settle_nxt = '0;
            w_col_nxt    = (r_col == CW'(COLS - 1)) ? '0 : r_col + 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      col_n = '1;
      if (r_state != IDLE)
         col_n[r_col] = 1'b0;
   end

   for (genvar k = 0; k < NK; k++) begin : g_key
      mk14_key_debounce #(
         .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_debounce (
         .CLK      (CLK),
         .rst_n    (rst_n),
         .i_en     (w_sample_en && (r_col == CW'(k / ROWS))),
         .i_sample (w_rows[k % ROWS]),
         .i_stable (r_keys[k]),
         .i_commit (w_commit_vec[k]),
         .o_cand   (w_cand[k])
      );
   end

   assign w_slot_free = !r_evt_valid || evt_ready;

   // Only the active column is enabled, so the lowest set index is the lowest row
   always_comb begin
      w_commit     = 1'b0;
      w_commit_idx = '0;
      w_commit_vec = '0;
      for (int k = NK - 1; k >= 0; k--) begin
         if (w_cand[k]) begin
            w_commit     = w_slot_free;
            w_commit_idx = KW'(k);
         end
      end
      if (w_commit)
         w_commit_vec[w_commit_idx] = 1'b1;
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int DELAY_CYC = CLOCK_FREQ_MHZ * 1000 * REPEAT_DELAY_MS;
   localparam int RATE_CYC  = CLOCK_FREQ_MHZ * 1000 * REPEAT_RATE_MS;

   logic          r_rep_active, r_rep_first, r_rep_pend, r_evt_repeat;
   logic [KW-1:0] r_rep_key;
   logic [31:0]   r_rep_timer;
   logic          w_rep_expire, w_rep_issue;

   assign w_rep_expire = r_rep_active &&
                         (r_rep_timer == (r_rep_first ? 32'(DELAY_CYC - 1) : 32'(RATE_CYC - 1)));
   assign w_rep_issue  = r_rep_pend && w_slot_free && !w_commit;

   // A newer press retargets tracking, which cancels repeat of the previous key
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_rep_active <= 1'b0;
         r_rep_first  <= 1'b0;
         r_rep_pend   <= 1'b0;
         r_rep_key    <= '0;
         r_rep_timer  <= '0;
      end else begin
         if (w_rep_issue)
            r_rep_pend <= 1'b0;
         if (w_rep_expire) begin
            r_rep_timer <= '0;
            r_rep_first <= 1'b0;
            r_rep_pend  <= 1'b1;
         end else if (r_rep_active) begin
            r_rep_timer <= r_rep_timer + 1'b1;
         end
         if (w_commit && !r_keys[w_commit_idx]) begin
            r_rep_active <= 1'b1;
            r_rep_key    <= w_commit_idx;
            r_rep_first  <= 1'b1;
            r_rep_timer  <= '0;
            r_rep_pend   <= 1'b0;
         end else if (w_commit && (w_commit_idx == r_rep_key)) begin
            r_rep_active <= 1'b0;
            r_rep_pend   <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst_n)
         r_evt_repeat <= 1'b0;
      else if (w_commit)
         r_evt_repeat <= 1'b0;
      else if (w_rep_issue)
         r_evt_repeat <= 1'b1;
   end

   assign evt_repeat = r_evt_repeat;
`endif

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         r_keys      <= '0;
         r_evt_valid <= 1'b0;
         r_evt_code  <= '0;
         r_evt_press <= 1'b0;
      end else if (w_commit) begin
         r_keys[w_commit_idx] <= ~r_keys[w_commit_idx];
         r_evt_valid          <= 1'b1;
         r_evt_code           <= w_commit_idx;
         r_evt_press          <= ~r_keys[w_commit_idx];
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      else if (w_rep_issue) begin
         r_evt_valid <= 1'b1;
         r_evt_code  <= r_rep_key;
         r_evt_press <= 1'b1;
      end
`endif
      else if (r_evt_valid && evt_ready) begin
         r_evt_valid <= 1'b0;
      end
   end

   assign keys      = r_keys;
   assign evt_valid = r_evt_valid;
   assign evt_code  = r_evt_code;
   assign evt_press = r_evt_press;

endmodule

`default_nettype wire

// File: tb/tb_mk14_keypad_scan.sv
// ============================================================================
// tb_mk14_keypad_scan : self-checking bench for mk14_keypad_scan
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mk14_keypad_scan;

   localparam int COLS = 8;
   localparam int ROWS = 4;
   localparam int NK   = 32;
   localparam int DB   = 4;

   logic            CLK = 1'b0;
   logic            rst_n = 1'b0;
   logic [7:0]      col_n;
   logic [3:0]      row_n;
   logic [31:0]     keys;
   logic            evt_valid;
   logic            evt_ready = 1'b0;
   logic [4:0]      evt_code;
   logic            evt_press;
`ifdef KEYPAD_AUTOREPEAT_EN
   logic            evt_repeat;
`endif
   logic [31:0]     pressed = '0;
   logic            chk_en = 1'b0;
   int              cyc = 0;
   int              n_chk = 0;
   int              n_pass = 0;

   always #5 CLK = ~CLK;

   mk14_keypad_scan #(
      .CLOCK_FREQ_MHZ (1),
      .COLS           (COLS),
      .ROWS           (ROWS),
      .SETTLE_US      (4),
`ifdef KEYPAD_AUTOREPEAT_EN
      .REPEAT_DELAY_MS(100),
      .REPEAT_RATE_MS (100),
`endif
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .col_n     (col_n),
      .row_n     (row_n),
      .keys      (keys),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
`ifdef KEYPAD_AUTOREPEAT_EN
      .evt_repeat(evt_repeat),
`endif
      .evt_press (evt_press)
   );

   // Physical keypad: a pressed key shorts its row to the driven-low column
   always_comb begin
      row_n = '1;
      for (int c = 0; c < COLS; c++)
         if (!col_n[c])
            for (int r = 0; r < ROWS; r++)
               if (pressed[c*ROWS + r]) row_n[r] = 1'b0;
   end

   always @(posedge CLK) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [7:0] exp_col(input int k);
      logic [7:0] one;
      one = 8'h01;
      if (k == 0) return 8'hFF;
      return ~(one << (((k - 1) / 4) % COLS));
   endfunction

   // Reference model: per-scan debounce, one commit per column visit, single event slot
   int          m_cnt [NK];
   logic [31:0] m_keys;
   logic        m_valid, m_press;
   logic [4:0]  m_code;

   always @(posedge CLK) begin : model
      int col, win, key;
      int nc [ROWS];
      bit acc;
      if (!rst_n) begin
         m_keys  <= '0;
         m_valid <= 1'b0;
         m_code  <= '0;
         m_press <= 1'b0;
         for (int i = 0; i < NK; i++) m_cnt[i] <= 0;
      end else begin
         acc = m_valid && evt_ready;
         if (acc) m_valid <= 1'b0;
         if (cyc >= 4 && cyc % 4 == 0) begin
            col = ((cyc - 1) / 4) % COLS;
            win = -1;
            for (int r = 0; r < ROWS; r++) begin
               key = col*ROWS + r;
               if (pressed[key] == m_keys[key]) nc[r] = 0;
               else nc[r] = (m_cnt[key] >= DB) ? DB : m_cnt[key] + 1;
               if (nc[r] == DB && win < 0) win = r;
            end
            if (win >= 0 && (!m_valid || acc)) begin
               key     = col*ROWS + win;
               nc[win] = 0;
               m_keys[key] <= ~m_keys[key];
               m_valid     <= 1'b1;
               m_code      <= 5'(key);
               m_press     <= ~m_keys[key];
            end
            for (int r = 0; r < ROWS; r++) m_cnt[col*ROWS + r] <= nc[r];
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en && rst_n) begin
         check("col_n", 32'(col_n), 32'(exp_col(cyc)));
         check("keys", keys, m_keys);
         check("evt_valid", 32'(evt_valid), 32'(m_valid));
         if (m_valid) begin
            check("evt_code", 32'(evt_code), 32'(m_code));
            check("evt_press", 32'(evt_press), 32'(m_press));
`ifdef KEYPAD_AUTOREPEAT_EN
            check("evt_repeat", 32'(evt_repeat), 32'd0);
`endif
         end
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic wait_boundary();
      for (int i = 0; i < 40 && (cyc % 32) != 1; i++) tick();
      check("scan_align", 32'(cyc % 32), 32'd1);
   endtask

   typedef struct {
      logic [31:0] mask;
      int          scans;
      logic [31:0] exp_keys;
   } vec_t;

   vec_t vecs [13];
   bit   found;
   int   idx;

   initial begin
      vecs[0]  = '{32'h0040_0000, 3, 32'h0000_0000};
      vecs[1]  = '{32'h0000_0000, 1, 32'h0000_0000};
      vecs[2]  = '{32'h0040_0000, 4, 32'h0040_0000};
      vecs[3]  = '{32'h0000_0000, 4, 32'h0000_0000};
      vecs[4]  = '{32'h0000_0050, 4, 32'h0000_0010};
      vecs[5]  = '{32'h0000_0050, 1, 32'h0000_0050};
      vecs[6]  = '{32'h0000_0000, 3, 32'h0000_0050};
      vecs[7]  = '{32'h0000_0000, 2, 32'h0000_0000};
      vecs[8]  = '{32'h8000_0001, 4, 32'h8000_0001};
      vecs[9]  = '{32'h0000_0000, 4, 32'h0000_0000};
      vecs[10] = '{32'h0000_0F00, 4, 32'h0000_0100};
      vecs[11] = '{32'h0000_0F00, 3, 32'h0000_0F00};
      vecs[12] = '{32'h0000_0000, 7, 32'h0000_0000};

      evt_ready = 1'b1;
      repeat (3) tick();
      check("rst_col_n", 32'(col_n), 32'h0000_00FF);
      check("rst_keys", keys, 32'h0);
      check("rst_evt_valid", 32'(evt_valid), 32'h0);
      check("rst_evt_code", 32'(evt_code), 32'h0);
      check("rst_evt_press", 32'(evt_press), 32'h0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("idle_col_n", 32'(col_n), 32'h0000_00FF);

      wait_boundary();
      for (int v = 0; v < 13; v++) begin
         pressed = vecs[v].mask;
         repeat (vecs[v].scans * 32) tick();
         check($sformatf("tbl_keys[%0d]", v), keys, vecs[v].exp_keys);
      end

      // Two keys in one column with the consumer stalled
      evt_ready = 1'b0;
      pressed   = 32'h0000_0050;
      repeat (5 * 32) tick();
      check("stall_valid", 32'(evt_valid), 32'h1);
      check("stall_code", 32'(evt_code), 32'd4);
      check("stall_keys", keys, 32'h0000_0010);
      evt_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (evt_valid && evt_code == 5'd6) found = 1'b1;
      end
      check("evt6_arrives", 32'(found), 32'h1);
      check("evt6_keys", keys, 32'h0000_0050);
      wait_boundary();
      pressed = '0;
      repeat (10 * 32) tick();
      check("release_keys", keys, 32'h0);

      // Reset with an event pending and the key still held
      wait_boundary();
      evt_ready = 1'b0;
      pressed   = 32'h0040_0000;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         if (evt_valid) found = 1'b1;
      end
      check("pre_rst_valid", 32'(found), 32'h1);
      check("pre_rst_code", 32'(evt_code), 32'd22);
      rst_n  = 1'b0;
      chk_en = 1'b0;
      tick();
      check("mid_rst_valid", 32'(evt_valid), 32'h0);
      check("mid_rst_keys", keys, 32'h0);
      check("mid_rst_col_n", 32'(col_n), 32'h0000_00FF);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      for (int i = 0; i < 200 && !evt_valid; i++) tick();
      check("repress_cycle", 32'(cyc), 32'd121);
      check("repress_code", 32'(evt_code), 32'd22);
      check("repress_press", 32'(evt_press), 32'h1);
      evt_ready = 1'b1;
      pressed   = '0;
      repeat (6 * 32) tick();

      // Random key activity and random back-pressure against the model
      wait_boundary();
      for (int s = 0; s < 80; s++) begin
         if ($urandom_range(0, 1) == 0) begin
            idx = $urandom_range(0, 31);
            pressed[idx] = ~pressed[idx];
         end
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, 31);
            pressed[idx] = ~pressed[idx];
         end
         for (int t = 0; t < 32; t++) begin
            evt_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
